// File: rtl/id_ex_stage_pkg.sv
// Shared decoder encodings and the ID/EX control word.
package cpu_pkg;

    // alu_op encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_LOG  = 3'b010;
    localparam logic [2:0] ALU_SHF  = 3'b011;
    localparam logic [2:0] ALU_CMP  = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    // branch class encodings
    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_COND  = 2'b01;
    localparam logic [1:0] BR_JAL   = 2'b10;
    localparam logic [1:0] BR_JALR  = 2'b11;

    // imm_type encodings
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_R    = 3'd5;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       pc_to_reg_src;
        logic       alu_src;
        logic       rd_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [1:0] branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op: ALU_ADD, pc_to_reg_src: 1'b0, alu_src: 1'b0, rd_src: 1'b0,
        mem_to_reg: 1'b0, mem_write: 1'b0, mem_read: 1'b0, reg_write: 1'b0,
        branch: BR_NONE
    };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [2:0] id_imm_type,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    output logic       load_use
);

    logic use_rs1;
    logic use_rs2;

    // U/J formats carry no rs1; rs2 is only read for reg-reg ALU ops and stores
    assign use_rs1 = (id_imm_type != IMM_U) && (id_imm_type != IMM_J);
    assign use_rs2 = !id_alu_src || id_mem_write;

    // x0 never carries a real dependency
    assign load_use = ex_valid && ex_mem_read && ex_reg_write && (ex_rd != 5'd0) && id_valid &&
                      ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and global hold.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [2:0]       id_alu_op_i,
    input  logic             id_pc_to_reg_src_i,
    input  logic             id_alu_src_i,
    input  logic             id_rd_src_i,
    input  logic             id_mem_to_reg_i,
    input  logic             id_mem_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_reg_write_i,
    input  logic [1:0]       id_branch_i,
    input  logic [2:0]       id_imm_type_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic [2:0]       id_funct3_i,
    input  logic [6:0]       id_funct7_i,
    output logic             ex_valid_o,
    output logic [2:0]       ex_alu_op_o,
    output logic             ex_pc_to_reg_src_o,
    output logic             ex_alu_src_o,
    output logic             ex_rd_src_o,
    output logic             ex_mem_to_reg_o,
    output logic             ex_mem_write_o,
    output logic             ex_mem_read_o,
    output logic             ex_reg_write_o,
    output logic [1:0]       ex_branch_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [2:0]       ex_funct3_o,
    output logic [6:0]       ex_funct7_o,
    output logic             load_use_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    ctrl_t ex_ctrl;
    ctrl_t id_ctrl;
    logic  load_use;

    assign id_ctrl = '{
        alu_op: id_alu_op_i, pc_to_reg_src: id_pc_to_reg_src_i, alu_src: id_alu_src_i,
        rd_src: id_rd_src_i, mem_to_reg: id_mem_to_reg_i, mem_write: id_mem_write_i,
        mem_read: id_mem_read_i, reg_write: id_reg_write_i, branch: id_branch_i
    };

    load_use_detect u_lud (
        .ex_valid     (ex_valid_o),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_reg_write (ex_ctrl.reg_write),
        .ex_rd        (ex_rd_o),
        .id_valid     (id_valid_i),
        .id_rs1       (id_rs1_i),
        .id_rs2       (id_rs2_i),
        .id_imm_type  (id_imm_type_i),
        .id_alu_src   (id_alu_src_i),
        .id_mem_write (id_mem_write_i),
        .load_use     (load_use)
    );

    // A squashed or frozen ID must not hold fetch
    assign load_use_stall_o = load_use && !flush_i && !stall_i;

    // Priority chain: hold > flush bubble > load-use bubble > capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl       <= CTRL_NOP;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_funct3_o   <= '0;
            ex_funct7_o   <= '0;
            bubble_cnt_o  <= '0;
        end else if (stall_i) begin
            // hold everything
        end else if (flush_i || load_use) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl       <= CTRL_NOP;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_funct3_o   <= '0;
            ex_funct7_o   <= '0;
            bubble_cnt_o  <= bubble_cnt_o + 1'b1;
        end else begin
            ex_valid_o    <= id_valid_i;
            ex_ctrl       <= id_ctrl;
            ex_pc_o       <= id_pc_i;
            ex_rs1_data_o <= id_rs1_data_i;
            ex_rs2_data_o <= id_rs2_data_i;
            ex_imm_o      <= id_imm_i;
            ex_rs1_o      <= id_rs1_i;
            ex_rs2_o      <= id_rs2_i;
            ex_rd_o       <= id_rd_i;
            ex_funct3_o   <= id_funct3_i;
            ex_funct7_o   <= id_funct7_i;
        end
    end

    assign ex_alu_op_o        = ex_ctrl.alu_op;
    assign ex_pc_to_reg_src_o = ex_ctrl.pc_to_reg_src;
    assign ex_alu_src_o       = ex_ctrl.alu_src;
    assign ex_rd_src_o        = ex_ctrl.rd_src;
    assign ex_mem_to_reg_o    = ex_ctrl.mem_to_reg;
    assign ex_mem_write_o     = ex_ctrl.mem_write;
    assign ex_mem_read_o      = ex_ctrl.mem_read;
    assign ex_reg_write_o     = ex_ctrl.reg_write;
    assign ex_branch_o        = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised + directed bench for id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam int WW    = 166;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_i = 0, flush_i = 0, id_valid_i = 0;
    logic [2:0] id_alu_op_i = 0;
    logic id_pc_to_reg_src_i = 0, id_alu_src_i = 0, id_rd_src_i = 0, id_mem_to_reg_i = 0;
    logic id_mem_write_i = 0, id_mem_read_i = 0, id_reg_write_i = 0;
    logic [1:0] id_branch_i = 0;
    logic [2:0] id_imm_type_i = 0;
    logic [XLEN-1:0] id_pc_i = 0, id_rs1_data_i = 0, id_rs2_data_i = 0, id_imm_i = 0;
    logic [4:0] id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0;
    logic [2:0] id_funct3_i = 0;
    logic [6:0] id_funct7_i = 0;

    logic ex_valid_o;
    logic [2:0] ex_alu_op_o;
    logic ex_pc_to_reg_src_o, ex_alu_src_o, ex_rd_src_o, ex_mem_to_reg_o;
    logic ex_mem_write_o, ex_mem_read_o, ex_reg_write_o;
    logic [1:0] ex_branch_o;
    logic [XLEN-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [2:0] ex_funct3_o;
    logic [6:0] ex_funct7_o;
    logic load_use_stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int checks = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_alu_op_i(id_alu_op_i), .id_pc_to_reg_src_i(id_pc_to_reg_src_i),
        .id_alu_src_i(id_alu_src_i), .id_rd_src_i(id_rd_src_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_read_i(id_mem_read_i),
        .id_reg_write_i(id_reg_write_i), .id_branch_i(id_branch_i), .id_imm_type_i(id_imm_type_i),
        .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_funct3_i(id_funct3_i), .id_funct7_i(id_funct7_i),
        .ex_valid_o(ex_valid_o), .ex_alu_op_o(ex_alu_op_o), .ex_pc_to_reg_src_o(ex_pc_to_reg_src_o),
        .ex_alu_src_o(ex_alu_src_o), .ex_rd_src_o(ex_rd_src_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_branch_o(ex_branch_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct3_o(ex_funct3_o),
        .ex_funct7_o(ex_funct7_o), .load_use_stall_o(load_use_stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently in EX as a whole word, plus bubble count
    logic [WW-1:0]    m_word;
    logic             m_valid, m_mem_read, m_reg_write;
    logic [4:0]       m_rd;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [WW-1:0] id_word();
        return {id_valid_i, id_alu_op_i, id_pc_to_reg_src_i, id_alu_src_i, id_rd_src_i,
                id_mem_to_reg_i, id_mem_write_i, id_mem_read_i, id_reg_write_i, id_branch_i,
                id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
                id_funct3_i, id_funct7_i};
    endfunction

    function automatic logic [WW-1:0] ex_word();
        return {ex_valid_o, ex_alu_op_o, ex_pc_to_reg_src_o, ex_alu_src_o, ex_rd_src_o,
                ex_mem_to_reg_o, ex_mem_write_o, ex_mem_read_o, ex_reg_write_o, ex_branch_o,
                ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
                ex_funct3_o, ex_funct7_o};
    endfunction

    // Does the ID instruction read the register a load in EX is about to write?
    function automatic logic model_hazard();
        logic reads_rs1, reads_rs2;
        reads_rs1 = !(id_imm_type_i == IMM_U || id_imm_type_i == IMM_J);
        reads_rs2 = (id_alu_src_i == 1'b0) || id_mem_write_i;
        return m_valid && m_mem_read && m_reg_write && (m_rd != 0) && id_valid_i &&
               ((reads_rs1 && m_rd == id_rs1_i) || (reads_rs2 && m_rd == id_rs2_i));
    endfunction

    task automatic model_reset();
        m_word = '0; m_valid = 0; m_mem_read = 0; m_reg_write = 0; m_rd = 0; m_cnt = '0;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven; check stall mid-cycle, then registered state after edge.
    // want_stall: -1 no directed expectation, else constant expectation for load_use_stall_o.
    task automatic step(input string tag, input int want_stall);
        logic hz;
        @(negedge clk);
        hz = model_hazard();
        chk({tag, ":stall"}, 256'(load_use_stall_o), 256'(hz && !flush_i && !stall_i));
        if (want_stall >= 0) chk({tag, ":stall_dir"}, 256'(load_use_stall_o), 256'(want_stall));
        @(posedge clk);
        if (!stall_i) begin
            if (flush_i || hz) begin
                m_word = '0; m_valid = 0; m_mem_read = 0; m_reg_write = 0; m_rd = 0;
                m_cnt = m_cnt + 1;
            end else begin
                m_word = id_word(); m_valid = id_valid_i; m_mem_read = id_mem_read_i;
                m_reg_write = id_reg_write_i; m_rd = id_rd_i;
            end
        end
        #1;
        chk({tag, ":ex"}, 256'(ex_word()), 256'(m_word));
        chk({tag, ":cnt"}, 256'(bubble_cnt_o), 256'(m_cnt));
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] it, input logic asrc,
                             input logic mr, input logic mw, input logic rw);
        id_valid_i = v; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2; id_imm_type_i = it;
        id_alu_src_i = asrc; id_mem_read_i = mr; id_mem_write_i = mw; id_reg_write_i = rw;
        id_mem_to_reg_i = mr; id_alu_op_i = ALU_ADD; id_branch_i = BR_NONE;
        id_pc_i = id_pc_i + 4; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
        id_imm_i = $urandom; id_funct3_i = 3'($urandom); id_funct7_i = 7'($urandom);
    endtask

    task automatic lw_x5();
        set_instr(1, 5'd5, 5'd1, 5'd9, IMM_I, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw_x5", 0);
    endtask

    task automatic rand_inputs();
        stall_i = ($urandom % 8) == 0;
        flush_i = ($urandom % 8) == 0;
        id_valid_i = ($urandom % 8) != 0;
        id_alu_op_i = 3'($urandom); id_pc_to_reg_src_i = 1'($urandom);
        id_alu_src_i = 1'($urandom); id_rd_src_i = 1'($urandom); id_mem_to_reg_i = 1'($urandom);
        id_mem_write_i = ($urandom % 4) == 0; id_mem_read_i = ($urandom % 3) == 0;
        id_reg_write_i = ($urandom % 4) != 0; id_branch_i = 2'($urandom);
        id_imm_type_i = 3'($urandom % 6);
        id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
        id_rs1_i = 5'($urandom % 8); id_rs2_i = 5'($urandom % 8); id_rd_i = 5'($urandom % 8);
        id_funct3_i = 3'($urandom); id_funct7_i = 7'($urandom);
    endtask

    logic [CNT_W-1:0] c0;
    logic [WW-1:0]    w0;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ex", 256'(ex_word()), 256'(0));
        chk("reset_cnt", 256'(bubble_cnt_o), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // capture: add x3,x1,x2 at pc 0x40
        set_instr(1, 5'd3, 5'd1, 5'd2, IMM_R, 1'b0, 1'b0, 1'b0, 1'b1);
        id_pc_i = 32'h40;
        step("add_cap", 0);
        chk("add_rd", 256'(ex_rd_o), 256'(3));
        chk("add_pc", 256'(ex_pc_o), 256'(32'h40));
        chk("add_vld_rw_op", 256'({ex_valid_o, ex_reg_write_o, ex_alu_op_o}), 256'(5'b11_000));

        // load-use: lw x5 ; add x6,x5,x0
        c0 = bubble_cnt_o;
        lw_x5();
        set_instr(1, 5'd6, 5'd5, 5'd0, IMM_R, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_bubble", 1);
        chk("lu_bubble_vld", 256'(ex_valid_o), 256'(0));
        chk("lu_cnt", 256'(bubble_cnt_o), 256'(c0 + 1));
        step("lu_capture", 0);
        chk("lu_cap_rd", 256'(ex_rd_o), 256'(6));

        // lw x0 ; add x6,x0,x0 -> no stall
        set_instr(1, 5'd0, 5'd1, 5'd9, IMM_I, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw_x0", 0);
        set_instr(1, 5'd6, 5'd0, 5'd0, IMM_R, 1'b0, 1'b0, 1'b0, 1'b1);
        step("add_x0", 0);

        // no false hazards: lui x5, jal x5, addi x7,x1,5 after lw x5
        lw_x5();
        set_instr(1, 5'd5, 5'd5, 5'd5, IMM_U, 1'b1, 1'b0, 1'b0, 1'b1);
        step("lui", 0);
        lw_x5();
        set_instr(1, 5'd5, 5'd5, 5'd5, IMM_J, 1'b1, 1'b0, 1'b0, 1'b1);
        id_branch_i = BR_JAL;
        step("jal", 0);
        lw_x5();
        set_instr(1, 5'd7, 5'd1, 5'd5, IMM_I, 1'b1, 1'b0, 1'b0, 1'b1);
        step("addi", 0);

        // flush wins over hazard
        lw_x5();
        c0 = bubble_cnt_o;
        set_instr(1, 5'd6, 5'd5, 5'd0, IMM_R, 1'b0, 1'b0, 1'b0, 1'b1);
        flush_i = 1'b1;
        step("flush_hz", 0);
        chk("flush_cnt", 256'(bubble_cnt_o), 256'(c0 + 1));
        flush_i = 1'b0;

        // stall wins over flush and hazard; release applies flush
        lw_x5();
        c0 = bubble_cnt_o;
        w0 = ex_word();
        set_instr(1, 5'd6, 5'd5, 5'd0, IMM_R, 1'b0, 1'b0, 1'b0, 1'b1);
        stall_i = 1'b1; flush_i = 1'b1;
        step("stall_hold", 0);
        chk("stall_ex", 256'(ex_word()), 256'(w0));
        chk("stall_cnt", 256'(bubble_cnt_o), 256'(c0));
        stall_i = 1'b0;
        step("stall_rel", 0);
        chk("rel_cnt", 256'(bubble_cnt_o), 256'(c0 + 1));
        chk("rel_vld", 256'(ex_valid_o), 256'(0));
        flush_i = 1'b0;

        // reset mid-stream with a valid R-type held in EX
        set_instr(1, 5'd3, 5'd1, 5'd2, IMM_R, 1'b0, 1'b0, 1'b0, 1'b1);
        step("pre_rst", 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ex", 256'(ex_word()), 256'(0));
        chk("midrst_cnt", 256'(bubble_cnt_o), 256'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step("rand", -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
